drive_seq_monitor: RTL and testbench

DRIVE_SEQ_MONITOR -- requirements
Module: drive_seq_monitor

---
 rtl/drive_seq_monitor.sv | 184 ++++++++++++++++++
 tb/tb_drive_seq_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/drive_seq_monitor.sv
// Tracks the fixed {ch1_on,ch2_on,hold,fire} drive sequence frame by frame,
// flags the first deviating sample and keeps saturating frame/error tallies.
module drive_seq_monitor #(
    parameter int unsigned CH1_LEN  = 11,
    parameter int unsigned HOLD_LEN = 8,
    parameter int unsigned FIRE_LEN = 1,
    parameter int unsigned TAIL_LEN = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ch1_on,
    input  logic             ch2_on,
    input  logic             hold,
    input  logic             fire,
    input  logic             clr,
    output logic             locked,
    output logic [2:0]       phase,
    output logic             frame_done,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned FRAME = CH1_LEN + HOLD_LEN + FIRE_LEN + TAIL_LEN;
    localparam int unsigned PosW  = (FRAME > 2) ? $clog2(FRAME) : 1;

    localparam logic [PosW-1:0] HoldStart = PosW'(CH1_LEN);
    localparam logic [PosW-1:0] FireStart = PosW'(CH1_LEN + HOLD_LEN);
    localparam logic [PosW-1:0] TailStart = PosW'(CH1_LEN + HOLD_LEN + FIRE_LEN);
    localparam logic [PosW-1:0] LastPos   = PosW'(FRAME - 1);

    localparam logic [2:0] PhIdle = 3'd0;
    localparam logic [2:0] PhCh1  = 3'd1;
    localparam logic [2:0] PhHold = 3'd2;
    localparam logic [2:0] PhFire = 3'd3;
    localparam logic [2:0] PhTail = 3'd4;

    typedef enum logic {StIdle, StTrack} state_e;

    state_e           state_q, state_d;
    logic [PosW-1:0]  pos_q, pos_d;
    logic             locked_q, locked_d;
    logic [2:0]       phase_q, phase_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [3:0] sample;
    logic [3:0] exp_sample;
    logic [2:0] region;
    logic [2:0] code;
    logic       frame_inc;
    logic       err_inc;

    assign sample = {ch1_on, ch2_on, hold, fire};

    always_comb begin
        region     = PhTail;
        exp_sample = 4'b0100;
        if (pos_q < HoldStart) begin
            region     = PhCh1;
            exp_sample = 4'b1000;
        end else if (pos_q < FireStart) begin
            region     = PhHold;
            exp_sample = 4'b0110;
        end else if (pos_q < TailStart) begin
            region     = PhFire;
            exp_sample = 4'b0101;
        end
    end

    // Cause priority: channel overlap, then strobe overlap, then orphan strobe.
    always_comb begin
        code = 3'd4;
        if (ch1_on && ch2_on) begin
            code = 3'd1;
        end else if (hold && fire) begin
            code = 3'd2;
        end else if ((hold || fire) && !ch2_on) begin
            code = 3'd3;
        end
    end

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        locked_d     = locked_q;
        phase_d      = phase_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        frame_inc    = 1'b0;
        err_inc      = 1'b0;
        case (state_q)
            StIdle: begin
                if (sample == 4'b1000) begin
                    state_d = StTrack;
                    pos_d   = PosW'(1);
                    phase_d = PhCh1;
                end
            end
            StTrack: begin
                if (sample == exp_sample) begin
                    phase_d = region;
                    if (pos_q == LastPos) begin
                        pos_d        = '0;
                        frame_done_d = 1'b1;
                        frame_inc    = 1'b1;
                        locked_d     = 1'b1;
                    end else begin
                        pos_d = pos_q + PosW'(1);
                    end
                end else begin
                    // Offending sample is dropped; re-entry needs a fresh 1000.
                    state_d    = StIdle;
                    pos_d      = '0;
                    phase_d    = PhIdle;
                    locked_d   = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = code;
                    err_inc    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                pos_d   = '0;
                phase_d = PhIdle;
            end
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (clr) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end else begin
            if (frame_inc && (frame_cnt_q != {CNT_W{1'b1}})) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
            if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pos_q        <= '0;
            locked_q     <= 1'b0;
            phase_q      <= PhIdle;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 3'd0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            locked_q     <= locked_d;
            phase_q      <= phase_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked     = locked_q;
    assign phase      = phase_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_drive_seq_monitor.sv
// Directed bench for drive_seq_monitor: a reference model pushes the expected
// outputs of each driven sample; they are popped and compared after the edge.
module tb_drive_seq_monitor;

    localparam int CH1   = 11;
    localparam int HOLD  = 8;
    localparam int FIRE  = 1;
    localparam int TAIL  = 1;
    localparam int FRAME = CH1 + HOLD + FIRE + TAIL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ch1_on = 1'b0, ch2_on = 1'b0, hold = 1'b0, fire = 1'b0, clr = 1'b0;
    logic        locked, frame_done, err;
    logic [2:0]  phase, err_code;
    logic [15:0] frame_cnt, err_cnt;
    logic        locked2, frame_done2, err2;
    logic [2:0]  phase2, err_code2;
    logic [1:0]  frame_cnt2, err_cnt2;

    int checks = 0;
    int errors = 0;

    logic [53:0] sb[$];

    // Reference model state
    int m_st, m_pos, m_lock, m_ph, m_code, m_fc, m_ec, m_fc2, m_ec2;

    drive_seq_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch1_on     (ch1_on),
        .ch2_on     (ch2_on),
        .hold       (hold),
        .fire       (fire),
        .clr        (clr),
        .locked     (locked),
        .phase      (phase),
        .frame_done (frame_done),
        .err        (err),
        .err_code   (err_code),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    drive_seq_monitor #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch1_on     (ch1_on),
        .ch2_on     (ch2_on),
        .hold       (hold),
        .fire       (fire),
        .clr        (clr),
        .locked     (locked2),
        .phase      (phase2),
        .frame_done (frame_done2),
        .err        (err2),
        .err_code   (err_code2),
        .frame_cnt  (frame_cnt2),
        .err_cnt    (err_cnt2)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ideal(input int p);
        if (p < CH1) return 4'b1000;
        if (p < CH1 + HOLD) return 4'b0110;
        if (p < CH1 + HOLD + FIRE) return 4'b0101;
        return 4'b0100;
    endfunction

    function automatic int region(input int p);
        if (p < CH1) return 1;
        if (p < CH1 + HOLD) return 2;
        if (p < CH1 + HOLD + FIRE) return 3;
        return 4;
    endfunction

    function automatic logic [53:0] observed();
        return {locked, phase, frame_done, err, err_code, frame_cnt, err_cnt,
                locked2, phase2, frame_done2, err2, err_code2, frame_cnt2, err_cnt2};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_lock = 0; m_ph = 0; m_code = 0;
        m_fc = 0; m_ec = 0; m_fc2 = 0; m_ec2 = 0;
    endtask

    task automatic step(input logic [3:0] s, input logic c, input string tag);
        int fd;
        int er;
        logic [53:0] e;
        fd = 0;
        er = 0;
        if (m_st == 0) begin
            if (s == 4'b1000) begin
                m_st = 1; m_pos = 1; m_ph = 1;
            end
        end else if (s == ideal(m_pos)) begin
            m_ph = region(m_pos);
            if (m_pos == FRAME - 1) begin
                m_pos = 0; fd = 1; m_lock = 1;
            end else begin
                m_pos++;
            end
        end else begin
            er = 1; m_lock = 0; m_ph = 0; m_st = 0; m_pos = 0;
            if (s[3] && s[2]) m_code = 1;
            else if (s[1] && s[0]) m_code = 2;
            else if ((s[1] || s[0]) && !s[2]) m_code = 3;
            else m_code = 4;
        end
        if (fd != 0) begin
            if (m_fc < 65535) m_fc++;
            if (m_fc2 < 3) m_fc2++;
        end
        if (er != 0) begin
            if (m_ec < 65535) m_ec++;
            if (m_ec2 < 3) m_ec2++;
        end
        if (c) begin
            m_fc = 0; m_ec = 0; m_fc2 = 0; m_ec2 = 0;
        end
        e = {m_lock[0], m_ph[2:0], fd[0], er[0], m_code[2:0], m_fc[15:0], m_ec[15:0],
             m_lock[0], m_ph[2:0], fd[0], er[0], m_code[2:0], m_fc2[1:0], m_ec2[1:0]};
        sb.push_back(e);
        {ch1_on, ch2_on, hold, fire} = s;
        clr = c;
        @(posedge clk);
        #1;
        check(tag, 64'(observed()), 64'(sb.pop_front()));
    endtask

    task automatic run_frame(input string tag);
        for (int p = 0; p < FRAME; p++) step(ideal(p), 1'b0, tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'(observed()), 64'd0);
        rst_n = 1'b1;

        // Three ideal frames
        run_frame("ideal_f1");
        check("f1_locked", 64'(locked), 64'd1);
        run_frame("ideal_f2");
        run_frame("ideal_f3");
        check("f3_frame_cnt", 64'(frame_cnt), 64'd3);
        check("f3_err_cnt", 64'(err_cnt), 64'd0);

        // ch2_on forced at pos 5 of a locked frame
        for (int p = 0; p < 5; p++) step(ideal(p), 1'b0, "ovl_pre");
        step(4'b1100, 1'b0, "ovl_err");
        check("ovl_err_pulse", 64'(err), 64'd1);
        check("ovl_code", 64'(err_code), 64'd1);
        check("ovl_err_cnt", 64'(err_cnt), 64'd1);
        check("ovl_locked", 64'({locked, phase}), 64'd0);
        step(4'b0000, 1'b0, "ovl_after");
        check("ovl_err_one_cycle", 64'(err), 64'd0);

        // ch1_on held too long
        for (int i = 0; i < 12; i++) step(4'b1000, 1'b0, "long_ch1");
        check("long_code", 64'(err_code), 64'd4);
        check("long_err_cnt", 64'(err_cnt), 64'd2);
        run_frame("long_recover");
        check("long_frame_cnt", 64'(frame_cnt), 64'd4);
        check("long_locked", 64'(locked), 64'd1);

        // hold & fire together at pos 15
        for (int p = 0; p < 15; p++) step(ideal(p), 1'b0, "hf_pre");
        step(4'b0111, 1'b0, "hf_err");
        check("hf_code", 64'(err_code), 64'd2);

        // fire without ch2_on at pos 19
        for (int p = 0; p < 19; p++) step(ideal(p), 1'b0, "orph_pre");
        step(4'b0001, 1'b0, "orph_err");
        check("orph_code", 64'(err_code), 64'd3);

        // clr zeroes counters, keeps err_code
        step(4'b0000, 1'b1, "clr_idle");
        check("clr_counts", 64'({frame_cnt, err_cnt}), 64'd0);
        check("clr_keeps_code", 64'(err_code), 64'd3);

        // Asynchronous reset mid-frame, released in the channel-2 window
        run_frame("rst_lock");
        for (int p = 0; p < 9; p++) step(ideal(p), 1'b0, "rst_pre");
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async", 64'(observed()), 64'd0);
        for (int p = 9; p < 13; p++) begin
            {ch1_on, ch2_on, hold, fire} = ideal(p);
            @(posedge clk);
            #1;
            check("rst_held", 64'(observed()), 64'd0);
        end
        rst_n = 1'b1;
        for (int p = 13; p < FRAME; p++) step(ideal(p), 1'b0, "rst_idle_tail");
        check("rst_no_err", 64'(err_cnt), 64'd0);
        run_frame("rst_relock");
        check("rst_relocked", 64'(locked), 64'd1);

        // Narrow counter saturation, then clr against a same-cycle frame_done
        for (int f = 0; f < 4; f++) run_frame("sat_frames");
        check("sat_frame_cnt2", 64'(frame_cnt2), 64'd3);
        for (int p = 0; p < FRAME - 1; p++) step(ideal(p), 1'b0, "sat_pre");
        step(ideal(FRAME - 1), 1'b1, "sat_clr");
        check("sat_clr_done", 64'(frame_done2), 64'd1);
        check("sat_clr_cnt2", 64'(frame_cnt2), 64'd0);
        check("sat_clr_cnt", 64'(frame_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
